// File: rtl/iob_reset_sequencer.sv
// Reset sequencer: holds N_OUT resets until clock lock and DDR calibration (or a
// calibration timeout), then releases them in order at START/STEP cycle spacing.
`timescale 1ns/1ps

module iob_reset_sequencer #(
    parameter int N_OUT   = 3,
    parameter int START   = 5,
    parameter int STEP    = 10,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked_i,
    input  logic             calib_done_i,
    input  logic             sw_rst_i,
    output logic [N_OUT-1:0] rst_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        DELAY   = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] START_C   = CNT_W'(START);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [N_OUT-1:0] rst_nxt, rst_shift;
    logic             done_nxt, timeout_nxt;
    logic             locked_p0, locked_s, calib_p0, calib_s;
    logic             ready, abort;

    // Stage p0 -> s: two-flop synchronisers for the asynchronous status inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_p0 <= 1'b0;
            locked_s  <= 1'b0;
            calib_p0  <= 1'b0;
            calib_s   <= 1'b0;
        end else begin
            locked_p0 <= locked_i;
            locked_s  <= locked_p0;
            calib_p0  <= calib_done_i;
            calib_s   <= calib_p0;
        end
    end

    assign ready     = locked_s & (calib_s | timeout_o);
    assign abort     = ~locked_s | sw_rst_i;
    assign cnt_inc   = cnt + CNT_W'(1);
    // Releasing one bit per step is a left shift that pulls a zero into bit 0
    assign rst_shift = rst_o << 1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rst_nxt     = rst_o;
        done_nxt    = done_o;
        timeout_nxt = timeout_o;

        if (state != HOLD && abort) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            rst_nxt   = '1;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    rst_nxt  = '1;
                    done_nxt = 1'b0;
                    if (ready) begin
                        state_nxt = DELAY;
                        cnt_nxt   = '0;
                    end else if (!locked_s) begin
                        cnt_nxt = '0;
                    end else if (TIMEOUT_EN && !timeout_o) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == TIMEOUT_C)
                            timeout_nxt = 1'b1;
                    end
                end
                DELAY, RELEASE: begin
                    if (cnt_inc == ((state == DELAY) ? START_C : STEP_C)) begin
                        cnt_nxt = '0;
                        rst_nxt = rst_shift;
                        if (rst_shift == '0) begin
                            state_nxt = RUN;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                RUN: begin
                    done_nxt = 1'b1;
                end
                default: begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    rst_nxt   = '1;
                    done_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HOLD;
            cnt       <= '0;
            rst_o     <= '1;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rst_o     <= rst_nxt;
            done_o    <= done_nxt;
            timeout_o <= timeout_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Bench for iob_reset_sequencer: two instances (no timeout / TIMEOUT=100) share
// stimulus and are checked every cycle against a release-time reference model.
`timescale 1ns/1ps

module tb_iob_reset_sequencer;
    localparam int N     = 3;
    localparam int START = 5;
    localparam int STEP  = 10;
    localparam int TO_A  = 0;
    localparam int TO_B  = 100;
    localparam int HMAX  = 32768;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         locked_i = 1'b0;
    logic         calib_done_i = 1'b0;
    logic         sw_rst_i = 1'b0;
    logic [N-1:0] rst_a, rst_b;
    logic         done_a, done_b, tmo_a, tmo_b;
    logic [1:0]   st_a, st_b;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Input values present at each numbered clock edge since the last reset
    bit lk_h [HMAX];
    bit cl_h [HMAX];
    bit sw_h [HMAX];

    // Reference model per instance: sequencing flag, edge that left HOLD,
    // lock-wait counter and sticky timeout
    bit m_act [2];
    bit m_tmo [2];
    int m_st  [2];
    int m_wt  [2];
    int to_v  [2];

    iob_reset_sequencer #(.N_OUT(N), .START(START), .STEP(STEP), .TIMEOUT(TO_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .locked_i(locked_i), .calib_done_i(calib_done_i),
        .sw_rst_i(sw_rst_i), .rst_o(rst_a), .done_o(done_a), .timeout_o(tmo_a), .state_o(st_a)
    );

    iob_reset_sequencer #(.N_OUT(N), .START(START), .STEP(STEP), .TIMEOUT(TO_B), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .locked_i(locked_i), .calib_done_i(calib_done_i),
        .sw_rst_i(sw_rst_i), .rst_o(rst_b), .done_o(done_b), .timeout_o(tmo_b), .state_o(st_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_tmo[d] = 1'b0;
            m_st[d]  = 0;
            m_wt[d]  = 0;
        end
    endtask

    task automatic model_step();
        bit ls, cs;
        ls = (edge_n >= 3) ? lk_h[edge_n-2] : 1'b0;
        cs = (edge_n >= 3) ? cl_h[edge_n-2] : 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (m_act[d]) begin
                if (!ls || sw_h[edge_n]) begin
                    m_act[d] = 1'b0;
                    m_wt[d]  = 0;
                end
            end else if (ls && (cs || m_tmo[d])) begin
                m_act[d] = 1'b1;
                m_st[d]  = edge_n;
                m_wt[d]  = 0;
            end else if (!ls) begin
                m_wt[d] = 0;
            end else if (to_v[d] != 0 && !m_tmo[d]) begin
                m_wt[d]++;
                if (m_wt[d] == to_v[d]) m_tmo[d] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] er;
        logic         ed;
        logic [1:0]   es;
        int           el;
        for (int d = 0; d < 2; d++) begin
            if (m_act[d]) begin
                el = edge_n - m_st[d];
                for (int k = 0; k < N; k++)
                    er[k] = (el >= START + k*STEP) ? 1'b0 : 1'b1;
                ed = (el >= START + (N-1)*STEP);
                es = ed ? 2'd3 : ((el >= START) ? 2'd2 : 2'd1);
            end else begin
                er = '1;
                ed = 1'b0;
                es = 2'd0;
            end
            if (d == 0) begin
                chk("a_rst_o", rst_a, er);
                chk("a_done", done_a, ed);
                chk("a_state", st_a, es);
                chk("a_timeout", tmo_a, m_tmo[0]);
            end else begin
                chk("b_rst_o", rst_b, er);
                chk("b_done", done_b, ed);
                chk("b_state", st_b, es);
                chk("b_timeout", tmo_b, m_tmo[1]);
            end
        end
    endtask

    task automatic tick();
        lk_h[edge_n+1] = locked_i;
        cl_h[edge_n+1] = calib_done_i;
        sw_h[edge_n+1] = sw_rst_i;
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asserts rst between clock edges, checks immediately, releases on a falling edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int m, r, c, lo;
        to_v[0] = TO_A;
        to_v[1] = TO_B;
        model_reset();
        do_reset();

        // Nominal sequence: lock sampled at edge 1, calibration already done
        locked_i = 1'b1; calib_done_i = 1'b1; sw_rst_i = 1'b0;
        repeat (30) begin
            tick();
            if (edge_n == 2) chk("nom_hold", st_a, 2'd0);
            if (edge_n == 3) chk("nom_delay", st_a, 2'd1);
            if (edge_n == 7) chk("nom_r0_pre", rst_a, 3'b111);
            if (edge_n == 8) chk("nom_r0", rst_a, 3'b110);
            if (edge_n == 18) chk("nom_r1", rst_a, 3'b100);
            if (edge_n == 27) chk("nom_notdone", done_a, 1'b0);
            if (edge_n == 28) begin
                chk("nom_r2", rst_a, 3'b000);
                chk("nom_done", done_a, 1'b1);
                chk("nom_run", st_a, 2'd3);
            end
        end

        // Software reset pulse in RUN
        repeat ($urandom_range(1, 5)) tick();
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        chk("sw_hold", st_a, 2'd0);
        chk("sw_rst_all", rst_a, 3'b111);
        chk("sw_done", done_a, 1'b0);
        tick();
        chk("sw_delay", st_a, 2'd1);
        repeat (4) tick();
        chk("sw_r0_pre", rst_a, 3'b111);
        tick();
        chk("sw_r0", rst_a, 3'b110);

        // Software reset on the same edge as the rst_o[1] release
        repeat (9) tick();
        chk("coin_pre", rst_a, 3'b110);
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        chk("coin_r1_held", rst_a, 3'b111);
        chk("coin_hold", st_a, 2'd0);
        tick();
        chk("coin_delay", st_a, 2'd1);
        repeat (30) tick();
        chk("coin_done", done_a, 1'b1);

        // Lock lost during RELEASE, then regained
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        tick();
        chk("ld_delay", st_a, 2'd1);
        m = edge_n + $urandom_range(6, 22);
        while (edge_n < m - 1) tick();
        locked_i = 1'b0;
        tick();
        tick();
        chk("ld_release", st_a, 2'd2);
        tick();
        chk("ld_abort_rst", rst_a, 3'b111);
        chk("ld_abort_st", st_a, 2'd0);
        repeat (3) tick();
        locked_i = 1'b1;
        r = edge_n + 1;
        repeat (30) begin
            tick();
            if (edge_n == r + 1) chk("rl_hold", st_a, 2'd0);
            if (edge_n == r + 2) chk("rl_delay", st_a, 2'd1);
            if (edge_n == r + 7) chk("rl_r0", rst_a, 3'b110);
            if (edge_n == r + 17) chk("rl_r1", rst_a, 3'b100);
            if (edge_n == r + 27) begin
                chk("rl_r2", rst_a, 3'b000);
                chk("rl_done", done_a, 1'b1);
            end
        end

        // Random lock / calibration / software reset traffic
        lo = 0;
        repeat (1500) begin
            if ($urandom_range(0, 59) == 0) locked_i = ~locked_i;
            if ($urandom_range(0, 99) == 0) calib_done_i = ~calib_done_i;
            sw_rst_i = ($urandom_range(0, 24) == 0);
            if (!locked_i) lo++;
            tick();
        end
        sw_rst_i = 1'b0;

        // Calibration never arrives: instance B times out, instance A waits forever
        do_reset();
        locked_i = 1'b1; calib_done_i = 1'b0;
        while (edge_n < 10000) begin
            tick();
            if (edge_n == 101) chk("to_pre", tmo_b, 1'b0);
            if (edge_n == 102) chk("to_set", tmo_b, 1'b1);
            if (edge_n == 103) chk("to_delay", st_b, 2'd1);
            if (edge_n == 107) chk("to_r0_pre", rst_b, 3'b111);
            if (edge_n == 108) chk("to_r0", rst_b, 3'b110);
        end
        chk("wait_hold", st_a, 2'd0);
        chk("wait_rst", rst_a, 3'b111);
        chk("wait_tmo", tmo_a, 1'b0);
        chk("to_run", st_b, 2'd3);
        chk("to_sticky", tmo_b, 1'b1);

        // Calibration arrives late for instance A
        calib_done_i = 1'b1;
        c = edge_n + 1;
        repeat (30) begin
            tick();
            if (edge_n == c + 2) chk("cal_delay", st_a, 2'd1);
            if (edge_n == c + 7) chk("cal_r0", rst_a, 3'b110);
            if (edge_n == c + 27) begin
                chk("cal_r2", rst_a, 3'b000);
                chk("cal_done", done_a, 1'b1);
            end
        end
        chk("tmo_sticky_run", tmo_b, 1'b1);

        // Asynchronous reset in the middle of DELAY
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        repeat (3) tick();
        chk("pre_async", st_a, 2'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", rst_a, 3'b111);
        chk("async_state", st_a, 2'd0);
        chk("async_tmo", tmo_b, 1'b0);
        do_reset();
        repeat (30) tick();
        chk("final_done", done_a, 1'b1);

        if (lo < 0) $display("unreachable");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_reset_sequencer.md
Name: iob_reset_sequencer

Overview:
- Parametrised reset sequencer that generalises the single-pulse reset generator used in FPGA top-level wrappers.
- Holds N_OUT reset outputs asserted until the clock source is locked and memory calibration is done, or a calibration timeout expires.
- Then releases the outputs one by one, in order, at programmable intervals.
- Re-sequences on loss of lock or on a software reset request. Sits in top_system between the clock wizard / DDR controller and the system and peripheral reset inputs.

Parameters:
- N_OUT, 3, number of reset outputs (1..16); bit 0 is released first.
- START, 5, cycles from leaving HOLD until rst_o[0] is released (>=1).
- STEP, 10, cycles between successive releases (>=1).
- TIMEOUT, 0, cycles to wait for calib_done_i once lock is seen; 0 means wait forever.
- CNT_W, 16, width of the internal counter; must hold max(START+(N_OUT-1)*STEP, TIMEOUT).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- locked_i  in  1  PLL locked; asynchronous, synchronised internally with 2 flops
- calib_done_i  in  1  DDR calibration complete; asynchronous, synchronised internally with 2 flops
- sw_rst_i  in  1  synchronous single-cycle software reset request
- rst_o  out  N_OUT  active-high reset outputs
- done_o  out  1  all outputs released
- timeout_o  out  1  sticky; calibration timed out
- state_o  out  2  FSM state: HOLD=0, DELAY=1, RELEASE=2, RUN=3

Behaviour:
- Async reset:
  - rst_o all ones, done_o=0, timeout_o=0, state HOLD.
  - Synchroniser flops and counter cleared.
  - Takes effect immediately in any state, including mid-DELAY or mid-RELEASE.
- Synchronised signals: locked_s and calib_s are the 2-flop outputs. An input sampled at edge e is seen by the FSM at edge e+2.
- ready = locked_s & (calib_s | timeout_o).
- HOLD:
  - rst_o all ones, done_o=0.
  - If locked_s=1, calib_s=0, TIMEOUT!=0 and timeout_o=0: counter increments each edge. When it reaches TIMEOUT, timeout_o is set at that edge.
  - If locked_s=0: counter is held at 0.
  - If ready=1: go to DELAY and clear the counter.
- DELAY:
  - Counter increments each edge.
  - At the edge where the count reaches START: clear rst_o[0], clear the counter, go to RELEASE (or RUN if N_OUT=1).
- RELEASE:
  - Index k starts at 1.
  - Every STEP cycles, clear rst_o[k] and increment k.
  - The edge that clears rst_o[N_OUT-1] also sets done_o=1 and enters RUN.
- Timing rule: rst_o[k] falls exactly START + k*STEP cycles after the edge that leaves HOLD. Released bits stay low until re-sequencing.
- RUN: holds the outputs until an abort condition occurs.
- Abort: locked_s=0 or sw_rst_i=1 while in DELAY, RELEASE or RUN.
  - At the next edge: state HOLD, rst_o all ones, done_o=0, counter cleared.
  - Abort has priority over a release scheduled on the same edge.
- sw_rst_i in HOLD is ignored. HOLD always lasts at least 1 cycle after an abort.
- timeout_o is cleared only by rst. On re-sequence it remains set, so ready depends on locked_s only.
- Counter never wraps; CNT_W sizing is the integrator's responsibility.
- rst_o are registered outputs, glitch-free.

Test Plan:
- Nominal, defaults, calib_done_i=1, locked_i rises sampled at edge 1:
  - FSM leaves HOLD at edge 3.
  - rst_o[0] falls at edge 8, rst_o[1] at 18, rst_o[2] at 28.
  - done_o=1 and state_o=3 at edge 28.
- Timeout, TIMEOUT=100, calib_done_i stuck 0, locked sampled at edge 1:
  - timeout_o=1 at edge 102.
  - DELAY at edge 103; rst_o[0] falls at edge 108.
  - timeout_o stays 1 through RUN.
- TIMEOUT=0, calib_done_i=0 for 10000 cycles:
  - Stays in HOLD, rst_o=3'b111, timeout_o=0.
  - Raise calib_done_i: normal sequence follows.
- sw_rst_i pulse at edge n in RUN:
  - At edge n+1: rst_o=3'b111, done_o=0, state_o=0.
  - DELAY at n+2; rst_o[0] falls at n+7.
  - Same test with sw_rst_i coinciding with the rst_o[1] release edge: rst_o[1] stays 1.
- locked_i drops, sampled at edge m during RELEASE: at edge m+2, all rst_o=1 and state_o=0.
  - Re-raise locked_i: full sequence restarts with the nominal timing.
- Async rst asserted mid-DELAY, between clock edges: outputs return to reset values immediately, without waiting for a clock edge.
